wb_slave_mem_bfm: RTL and testbench



---
 rtl/wb_slave_mem_bfm.sv | 145 ++++++++++++++
 tb/tb_wb_slave_mem_bfm.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_mem_bfm.sv
// Wishbone B4 registered-feedback memory slave with classic, incrementing and wrap bursts.
// Optional WB_SLAVE_ERR_EN: out-of-range word indices terminate with ERR instead of wrapping.
module wb_slave_mem_bfm #(
    parameter int unsigned WB_ADDR_WIDTH = 32,
    parameter int unsigned WB_DATA_WIDTH = 32,
    parameter int unsigned MEM_WORDS     = 1024,
    parameter int unsigned WAIT_STATES   = 0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [WB_ADDR_WIDTH-1:0]   ADR,
    input  logic [WB_DATA_WIDTH-1:0]   DAT_W,
    output logic [WB_DATA_WIDTH-1:0]   DAT_R,
    input  logic                       CYC,
    input  logic                       STB,
    input  logic                       WE,
    input  logic [WB_DATA_WIDTH/8-1:0] SEL,
    input  logic [2:0]                 CTI,
    input  logic [1:0]                 BTE,
    output logic                       ACK,
    output logic                       ERR
);

    localparam int unsigned NUM_LANES  = WB_DATA_WIDTH / 8;
    localparam int unsigned BYTE_SHIFT = $clog2(NUM_LANES);
    localparam int unsigned IDX_W      = WB_ADDR_WIDTH - BYTE_SHIFT;
    localparam int unsigned MEM_AW     = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_next, wrap_mask;
    logic [7:0]         cnt_q, cnt_d;
    logic               hold_q, hold_d;
    logic               idx_oor;
    logic               beat;
    logic               wr_en;
    logic               ack_int;
    logic [MEM_AW-1:0]  mem_idx;

    logic [WB_DATA_WIDTH-1:0] mem [MEM_WORDS];

    if (BYTE_SHIFT > 0) begin : g_adr_lsb
        logic unused_adr_lsb;
        assign unused_adr_lsb = ^ADR[BYTE_SHIFT-1:0];
    end

    assign mem_idx = idx_q[MEM_AW-1:0];

`ifdef WB_SLAVE_ERR_EN
    assign idx_oor = (idx_q >= IDX_W'(MEM_WORDS));
`else
    assign idx_oor = 1'b0;
`endif

    assign beat  = (state_q == StAck) && CYC && STB;
    assign wr_en = beat && WE && !idx_oor;

    // Wrap bursts only carry within the low log2(N) bits; linear carries through the whole index.
    always_comb begin
        case (BTE)
            2'b01:   wrap_mask = IDX_W'(3);
            2'b10:   wrap_mask = IDX_W'(7);
            2'b11:   wrap_mask = IDX_W'(15);
            default: wrap_mask = '1;
        endcase
        idx_next = (idx_q & ~wrap_mask) | ((idx_q + IDX_W'(1)) & wrap_mask);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        hold_d  = 1'b0;
        case (state_q)
            StIdle: begin
                // hold_q blanks the edge right after a terminating beat so a lingering STB is ignored
                if (!hold_q && CYC && STB) begin
                    idx_d = ADR[WB_ADDR_WIDTH-1:BYTE_SHIFT];
                    if (WAIT_STATES == 0) begin
                        state_d = StAck;
                    end else begin
                        cnt_d   = 8'(WAIT_STATES);
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!CYC) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == 8'd1) begin
                    state_d = StAck;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StAck: begin
                if (!CYC) begin
                    state_d = StIdle;
                end else if (STB) begin
                    if (!idx_oor && CTI == 3'b010) begin
                        idx_d = idx_next;
                    end else begin
                        state_d = StIdle;
                        hold_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ack_int = (state_q == StAck) && !idx_oor;
        ACK     = ack_int;
        ERR     = (state_q == StAck) && idx_oor;
        DAT_R   = (ack_int && !WE) ? mem[mem_idx] : '0;
    end

    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (SEL[i]) mem[mem_idx][8*i +: 8] <= DAT_W[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_wb_slave_mem_bfm.sv
// Randomized self-checking bench: two slaves (0 and 3 wait states) against an array memory model.
module tb_wb_slave_mem_bfm;

    localparam int unsigned W_SLOW = 3;

    logic        clk, rstn;
    logic [31:0] adr, dat_w;
    logic        we;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        cyc0, stb0, cyc3, stb3;
    logic [31:0] dat_r0, dat_r3;
    logic        ack0, err0, ack3, err3;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [2][1024];

    wb_slave_mem_bfm #(.WAIT_STATES(0)) u_fast (
        .clk(clk), .rstn(rstn), .ADR(adr), .DAT_W(dat_w), .DAT_R(dat_r0),
        .CYC(cyc0), .STB(stb0), .WE(we), .SEL(sel), .CTI(cti), .BTE(bte),
        .ACK(ack0), .ERR(err0)
    );

    wb_slave_mem_bfm #(.WAIT_STATES(W_SLOW)) u_slow (
        .clk(clk), .rstn(rstn), .ADR(adr), .DAT_W(dat_w), .DAT_R(dat_r3),
        .CYC(cyc3), .STB(stb3), .WE(we), .SEL(sel), .CTI(cti), .BTE(bte),
        .ACK(ack3), .ERR(err3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic cur_ack(input bit sl);
        return sl ? ack3 : ack0;
    endfunction

    function automatic logic cur_err(input bit sl);
        return sl ? err3 : err0;
    endfunction

    function automatic logic [31:0] cur_dat(input bit sl);
        return sl ? dat_r3 : dat_r0;
    endfunction

    task automatic set_req(input bit sl, input logic v);
        if (sl) begin cyc3 = v; stb3 = v; end
        else    begin cyc0 = v; stb0 = v; end
    endtask

    function automatic int unsigned exp_lat(input bit sl);
        return sl ? W_SLOW + 1 : 1;
    endfunction

    // Word index of beat k in a burst, straight from the linear/wrap-N definitions.
    function automatic int unsigned exp_idx(input int unsigned start, input logic [1:0] b,
                                            input int unsigned k);
        int unsigned n;
        n = (b == 2'b01) ? 4 : (b == 2'b10) ? 8 : (b == 2'b11) ? 16 : 0;
        if (n == 0) return (start + k) % 1024;
        return (start - start % n) + (start % n + k) % n;
    endfunction

    task automatic model_write(input bit sl, input int unsigned w, input logic [3:0] s,
                               input logic [31:0] d);
        for (int i = 0; i < 4; i++)
            if (s[i]) model[sl][w % 1024][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic bus_classic(input bit sl, input logic [31:0] a, input logic w,
                               input logic [3:0] s, input logic [31:0] d,
                               output logic [31:0] rd, output int lat, output bit got_ack,
                               output bit got_err, output bit leak, output logic ack_after);
        adr = a; we = w; sel = s; dat_w = d; cti = 3'b000; bte = 2'b00;
        set_req(sl, 1'b1);
        lat = 0; leak = 0;
        while (lat < 300) begin
            @(posedge clk); #1;
            lat++;
            if (cur_ack(sl) || cur_err(sl)) break;
            if (cur_dat(sl) !== 32'h0) leak = 1;
        end
        got_ack = cur_ack(sl);
        got_err = cur_err(sl);
        rd      = cur_dat(sl);
        @(posedge clk); #1;
        set_req(sl, 1'b0);
        ack_after = cur_ack(sl) | cur_err(sl);
        @(posedge clk); #1;
    endtask

    task automatic bus_burst(input bit sl, input int unsigned start, input logic [1:0] b,
                             input int n, input logic w, input logic [31:0] wd [16],
                             output logic [31:0] rd [16], output int lat, output int ack_cycles,
                             output logic ack_after);
        for (int k = 0; k < 16; k++) rd[k] = '0;
        adr = start * 4; we = w; sel = 4'hf; bte = b; dat_w = wd[0];
        cti = (n == 1) ? 3'b111 : 3'b010;
        set_req(sl, 1'b1);
        lat = 0;
        while (lat < 300) begin
            @(posedge clk); #1;
            lat++;
            if (cur_ack(sl) || cur_err(sl)) break;
        end
        ack_cycles = 0;
        for (int k = 0; k < n; k++) begin
            if (!cur_ack(sl)) break;
            ack_cycles++;
            rd[k] = cur_dat(sl);
            dat_w = wd[k];
            cti   = (k == n - 1) ? 3'b111 : 3'b010;
            @(posedge clk); #1;
        end
        set_req(sl, 1'b0);
        ack_after = cur_ack(sl) | cur_err(sl);
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        checks++;
        if ({ack0, err0, ack3, err3} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {ack0, err0, ack3, err3});
        end
        checks++;
        if (dat_r0 !== 32'h0 || dat_r3 !== 32'h0) begin
            errors++;
            $display("FAIL reset_dat_r: got %h/%h expected 0", dat_r0, dat_r3);
        end
    endtask

    task automatic test_preload;
        logic [31:0] rd, d;
        int lat;
        bit ga, ge, lk;
        logic aa;
        for (int sl = 0; sl < 2; sl++) begin
            for (int w = 0; w < 64; w++) begin
                d = $urandom;
                bus_classic(sl[0], 32'(w * 4), 1'b1, 4'hf, d, rd, lat, ga, ge, lk, aa);
                model_write(sl[0], w, 4'hf, d);
                checks++;
                if (!ga || lat != int'(exp_lat(sl[0]))) begin
                    errors++;
                    $display("FAIL preload_ack: dut %0d word %0d ack %0b lat %0d expected 1/%0d",
                             sl, w, ga, lat, exp_lat(sl[0]));
                end
            end
        end
    endtask

    task automatic test_classic;
        logic [31:0] rd;
        int lat;
        bit ga, ge, lk;
        logic aa;
        bus_classic(1'b0, 32'h10, 1'b1, 4'hf, 32'hDEADBEEF, rd, lat, ga, ge, lk, aa);
        model_write(1'b0, 4, 4'hf, 32'hDEADBEEF);
        checks++;
        if (!ga || lat != 1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL classic_write: ack %0b lat %0d dat_r %h expected 1/1/0", ga, lat, rd);
        end
        bus_classic(1'b0, 32'h10, 1'b0, 4'hf, 32'h0, rd, lat, ga, ge, lk, aa);
        checks++;
        if (!ga || lat != 1 || aa !== 1'b0) begin
            errors++;
            $display("FAIL classic_read_ack: ack %0b lat %0d ack_after %0b expected 1/1/0",
                     ga, lat, aa);
        end
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL classic_read_data: got %h expected deadbeef", rd);
        end
    endtask

    task automatic test_byte_lane;
        logic [31:0] rd;
        int lat;
        bit ga, ge, lk;
        logic aa;
        bus_classic(1'b0, 32'h20, 1'b1, 4'hf, 32'h11223344, rd, lat, ga, ge, lk, aa);
        bus_classic(1'b0, 32'h20, 1'b1, 4'b0010, 32'h0000AA00, rd, lat, ga, ge, lk, aa);
        model_write(1'b0, 8, 4'hf, 32'h11223344);
        model_write(1'b0, 8, 4'b0010, 32'h0000AA00);
        bus_classic(1'b0, 32'h20, 1'b0, 4'hf, 32'h0, rd, lat, ga, ge, lk, aa);
        checks++;
        if (rd !== 32'h1122AA44) begin
            errors++;
            $display("FAIL byte_lane: got %h expected 1122aa44", rd);
        end
    endtask

    task automatic test_wait_states;
        logic [31:0] rd;
        int lat;
        bit ga, ge, lk;
        logic aa;
        bus_classic(1'b1, 32'h30, 1'b0, 4'hf, 32'h0, rd, lat, ga, ge, lk, aa);
        checks++;
        if (!ga || lat != int'(W_SLOW + 1)) begin
            errors++;
            $display("FAIL wait_latency: ack %0b lat %0d expected 1/%0d", ga, lat, W_SLOW + 1);
        end
        checks++;
        if (lk || aa !== 1'b0) begin
            errors++;
            $display("FAIL wait_quiet: dat_r leak %0b ack_after %0b expected 0/0", lk, aa);
        end
        checks++;
        if (rd !== model[1][12]) begin
            errors++;
            $display("FAIL wait_data: got %h expected %h", rd, model[1][12]);
        end
    endtask

    task automatic test_bursts;
        logic [31:0] wd [16];
        logic [31:0] rd [16];
        int lat, nack, w;
        logic aa;
        for (int k = 0; k < 16; k++) wd[k] = '0;
        // wrap-4 read from 0x38: words 14,15,12,13
        bus_burst(1'b0, 14, 2'b01, 4, 1'b0, wd, rd, lat, nack, aa);
        checks++;
        if (lat != 1 || nack != 4 || aa !== 1'b0) begin
            errors++;
            $display("FAIL wrap4_ack: lat %0d beats %0d ack_after %0b expected 1/4/0",
                     lat, nack, aa);
        end
        for (int k = 0; k < 4; k++) begin
            w = int'(exp_idx(14, 2'b01, k));
            checks++;
            if (rd[k] !== model[0][w]) begin
                errors++;
                $display("FAIL wrap4_data: beat %0d got %h expected %h", k, rd[k], model[0][w]);
            end
        end
        // wrap-8 write on the slow slave, read back linearly
        for (int k = 0; k < 16; k++) wd[k] = $urandom;
        bus_burst(1'b1, 21, 2'b10, 8, 1'b1, wd, rd, lat, nack, aa);
        for (int k = 0; k < 8; k++) model_write(1'b1, exp_idx(21, 2'b10, k), 4'hf, wd[k]);
        checks++;
        if (lat != int'(W_SLOW + 1) || nack != 8 || aa !== 1'b0) begin
            errors++;
            $display("FAIL wrap8_write_ack: lat %0d beats %0d ack_after %0b expected %0d/8/0",
                     lat, nack, aa, W_SLOW + 1);
        end
        bus_burst(1'b1, 16, 2'b00, 8, 1'b0, wd, rd, lat, nack, aa);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (rd[k] !== model[1][16 + k]) begin
                errors++;
                $display("FAIL linear_read: word %0d got %h expected %h",
                         16 + k, rd[k], model[1][16 + k]);
            end
        end
        // wrap-16 read from word 37
        bus_burst(1'b0, 37, 2'b11, 16, 1'b0, wd, rd, lat, nack, aa);
        checks++;
        if (nack != 16) begin
            errors++;
            $display("FAIL wrap16_beats: got %0d expected 16", nack);
        end
        for (int k = 0; k < 16; k++) begin
            w = int'(exp_idx(37, 2'b11, k));
            checks++;
            if (rd[k] !== model[0][w]) begin
                errors++;
                $display("FAIL wrap16_data: beat %0d got %h expected %h", k, rd[k], model[0][w]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int n;
        logic [2:0] acks;
        adr = 32'h10; we = 1'b0; sel = 4'hf; cti = 3'b000; bte = 2'b00;
        set_req(1'b0, 1'b1);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!ack0 && n < 50);
        @(posedge clk); #1; acks[0] = ack0;
        @(posedge clk); #1; acks[1] = ack0;
        set_req(1'b0, 1'b0);
        @(posedge clk); #1; acks[2] = ack0;
        checks++;
        if (n != 1 || acks !== 3'b000) begin
            errors++;
            $display("FAIL stb_linger: first ack after %0d, later acks %b expected 1/000", n, acks);
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, d;
        int lat;
        bit ga, ge, lk, sl;
        logic aa, w;
        logic [3:0] s;
        int unsigned wd;
        for (int t = 0; t < 60; t++) begin
            sl = 1'($urandom_range(0, 1));
            wd = $urandom_range(0, 63);
            w  = 1'($urandom_range(0, 1));
            s  = 4'($urandom_range(1, 15));
            d  = $urandom;
            bus_classic(sl, 32'(wd * 4), w, s, d, rd, lat, ga, ge, lk, aa);
            checks++;
            if (!ga || ge || lat != int'(exp_lat(sl)) || aa !== 1'b0 || lk) begin
                errors++;
                $display("FAIL rand_handshake: op %0d ack %0b err %0b lat %0d after %0b leak %0b",
                         t, ga, ge, lat, aa, lk);
            end
            if (w) begin
                model_write(sl, wd, s, d);
            end else begin
                checks++;
                if (rd !== model[sl][wd]) begin
                    errors++;
                    $display("FAIL rand_read: dut %0d word %0d got %h expected %h",
                             sl, wd, rd, model[sl][wd]);
                end
            end
        end
    endtask

    task automatic test_reset_burst;
        logic [31:0] rd, d0, d1, old41;
        int lat;
        bit ga, ge, lk;
        logic aa;
        d0 = $urandom; d1 = ~d0; old41 = model[0][41];
        adr = 40 * 4; we = 1'b1; sel = 4'hf; cti = 3'b010; bte = 2'b00; dat_w = d0;
        set_req(1'b0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        dat_w = d1;
        checks++;
        if (ack0 !== 1'b1) begin
            errors++;
            $display("FAIL rst_burst_beat2: ack got %b expected 1", ack0);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({ack0, err0} !== 2'b00 || dat_r0 !== 32'h0) begin
            errors++;
            $display("FAIL rst_burst_drop: ack/err %b dat_r %h expected 00/0", {ack0, err0}, dat_r0);
        end
        set_req(1'b0, 1'b0);
        #2 rstn = 1'b1;
        @(posedge clk); #1;
        model_write(1'b0, 40, 4'hf, d0);
        bus_classic(1'b0, 41 * 4, 1'b0, 4'hf, 32'h0, rd, lat, ga, ge, lk, aa);
        checks++;
        if (!ga || lat != 1 || rd !== old41) begin
            errors++;
            $display("FAIL rst_burst_word2: ack %0b lat %0d got %h expected 1/1/%h",
                     ga, lat, rd, old41);
        end
        bus_classic(1'b0, 40 * 4, 1'b0, 4'hf, 32'h0, rd, lat, ga, ge, lk, aa);
        checks++;
        if (rd !== model[0][40]) begin
            errors++;
            $display("FAIL rst_burst_word1: got %h expected %h", rd, model[0][40]);
        end
    endtask

    task automatic test_out_of_range;
        logic [31:0] rd;
        int lat;
        bit ga, ge, lk;
        logic aa;
        bus_classic(1'b0, 32'h1000, 1'b0, 4'hf, 32'h0, rd, lat, ga, ge, lk, aa);
`ifdef WB_SLAVE_ERR_EN
        checks++;
        if (!ge || ga || rd !== 32'h0 || aa !== 1'b0) begin
            errors++;
            $display("FAIL oor_err: err %0b ack %0b dat_r %h after %0b expected 1/0/0/0",
                     ge, ga, rd, aa);
        end
`else
        checks++;
        if (!ga || ge || rd !== model[0][0] || aa !== 1'b0) begin
            errors++;
            $display("FAIL oor_wrap: ack %0b err %0b dat_r %h expected 1/0/%h",
                     ga, ge, rd, model[0][0]);
        end
`endif
    endtask

    initial begin
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 1024; w++) model[s][w] = '0;
        rstn = 1'b0;
        adr = '0; dat_w = '0; we = 1'b0; sel = '0; cti = '0; bte = '0;
        cyc0 = 1'b0; stb0 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        rstn = 1'b1;
        @(posedge clk); #1;
        test_preload;
        test_classic;
        test_byte_lane;
        test_wait_states;
        test_bursts;
        test_back_to_back;
        test_random;
        test_reset_burst;
        test_out_of_range;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
